regfile_mp: RTL and testbench

- Parametrised multi-read-port register file for the single-cycle and upcoming pipelined datapaths.
- Provides NUM_RD registered read ports with 1-cycle latency and one write port with optional write-to-read bypass.
- Optional hardwired zero register, a per-register pending-write scoreboard for hazard detection, and a sequential bulk-clear engine.
- Sits between decode (read addresses, reservations) and writeback (write port).

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_scoreboard.sv | 53 +++++
 rtl/regfile_mp.sv | 123 ++++++++++++
 tb/tb_regfile_mp.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register file and the decode/writeback blocks
// that talk to it: default widths, depth derivation and clear FSM states.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Every address value is a real register: DEPTH = 2**ADDR_W.
    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by a reservation,
// cleared by the matching writeback or by the bulk-clear sweep. Lookups
// report the value the bit will hold after the current edge.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     set_en,
    input  logic [ADDR_W-1:0]        set_addr,
    input  logic                     drop_en,
    input  logic [ADDR_W-1:0]        drop_addr,
    input  logic                     wipe_en,
    input  logic [ADDR_W-1:0]        wipe_addr,
    input  logic [NUM_RD*ADDR_W-1:0] look_addr,
    output logic [NUM_RD-1:0]        look_next
);

    localparam int DEPTH = depth_of(ADDR_W);

    logic [DEPTH-1:0] pend;
    logic [DEPTH-1:0] pend_next;

    // Next pending vector: writeback clears, a newer reservation on the same
    // register wins over it, the clear sweep and the zero register force 0.
    always_comb begin
        // NOTE: start from the held value so every path assigns pend_next and no latch is inferred.
        pend_next = pend;
        if (drop_en) pend_next[drop_addr] = 1'b0;
        if (set_en)  pend_next[set_addr]  = 1'b1;
        if (wipe_en) pend_next[wipe_addr] = 1'b0;
        if (ZERO_REG != 0) pend_next[0] = 1'b0;
    end

    // Pending register, cleared asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
        if (reset) pend <= '0;
        else       pend <= pend_next;
    end

    // Lookups see post-edge state so they agree with write bypass.
    always_comb begin
        look_next = '0;
        for (int i = 0; i < NUM_RD; i++)
            look_next[i] = pend_next[look_addr[i*ADDR_W +: ADDR_W]];
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file: NUM_RD registered read ports, one write
// port with optional same-edge bypass, optional hardwired zero register,
// pending-write scoreboard and a one-register-per-cycle bulk clear.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_pending,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic                     clr_req,
    output logic                     clr_busy
);

    localparam int DEPTH = depth_of(ADDR_W);

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   ptr;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   rd_value [NUM_RD];
    logic [NUM_RD-1:0]   look_next;
    logic                clearing;
    logic                wr_ok;
    logic                rsv_ok;

    assign clearing = (state == ST_CLEAR);
    assign clr_busy = clearing;
    // Writes and reservations are dropped while clearing; writes to the
    // hardwired zero register are dropped always.
    assign wr_ok    = wr_en && !clearing && !(ZERO_REG != 0 && wr_addr == '0);
    assign rsv_ok   = rsv_en && !clearing;

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clock     (clock),
        .reset     (reset),
        .set_en    (rsv_ok),
        .set_addr  (rsv_addr),
        .drop_en   (wr_ok),
        .drop_addr (wr_addr),
        .wipe_en   (clearing),
        .wipe_addr (ptr),
        .look_addr (rd_addr),
        .look_next (look_next)
    );

    // Clear FSM next state: sweep starts on clr_req, ends after the last register.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (clr_req) state_next = ST_CLEAR;
            ST_CLEAR: if (&ptr)    state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // FSM state and sweep pointer; the pointer wraps to 0 after DEPTH-1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            ptr   <= '0;
        end else begin
            state <= state_next;
            if (clearing) ptr <= ptr + 1'b1;
        end
    end

    // Storage: the sweep has priority, otherwise the accepted write lands.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: the whole array is async-reset here, so it maps to flops, not a RAM macro.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clearing) begin
            mem[ptr] <= '0;
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Per-port read value: array, forwarded write data, or forced zero.
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rd_value[i] = mem[rd_addr[i*ADDR_W +: ADDR_W]];
            if (BYPASS != 0 && wr_ok && wr_addr == rd_addr[i*ADDR_W +: ADDR_W])
                rd_value[i] = wr_data;
            if (clearing || (ZERO_REG != 0 && rd_addr[i*ADDR_W +: ADDR_W] == '0))
                rd_value[i] = '0;
        end
    end

    // Registered read ports; a disabled port holds its last data and pending bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data    <= '0;
            rd_pending <= '0;
        end else begin
            for (int i = 0; i < NUM_RD; i++) begin
                if (rd_en[i]) begin
                    rd_data[i*DATA_W +: DATA_W] <= rd_value[i];
                    rd_pending[i]               <= clearing ? 1'b0 : look_next[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: two instances (bypass on / off) share stimulus.
// Directed table, hand-written clear/reset sequences, then random traffic
// compared against an array-based reference model.
module tb_regfile_mp;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 32;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        clr_req;

    logic [63:0] data_bp, data_nb;
    logic [1:0]  pend_bp, pend_nb;
    logic        busy_bp, busy_nb;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) dut_bp (
        .clock(clock), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(data_bp), .rd_pending(pend_bp), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .clr_req(clr_req),
        .clr_busy(busy_bp)
    );

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clock(clock), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(data_nb), .rd_pending(pend_nb), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .clr_req(clr_req),
        .clr_busy(busy_nb)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic re, input logic [4:0] ra,
                         input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1);
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        rsv_en   = re;
        rsv_addr = ra;
        rd_en    = en;
        rd_addr  = {a1, a0};
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 2'b00, 5'd0, 5'd0);
        clr_req = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " bp data0"}, data_bp[31:0], 32'd0);
        check({tag, " bp data1"}, data_bp[63:32], 32'd0);
        check({tag, " nb data0"}, data_nb[31:0], 32'd0);
        check({tag, " nb data1"}, data_nb[63:32], 32'd0);
        check({tag, " bp pend"}, {30'd0, pend_bp}, 32'd0);
        check({tag, " nb pend"}, {30'd0, pend_nb}, 32'd0);
        check({tag, " busy"}, {30'd0, busy_nb, busy_bp}, 32'd0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        re;
        logic [4:0]  ra;
        logic [1:0]  en;
        logic [4:0]  a0, a1;
        logic [31:0] bp0, bp1, nb0, nb1;
        logic [1:0]  pnd;
    } vec_t;

    vec_t tbl [14];

    function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic re, input logic [4:0] ra, input logic [1:0] en,
                                input logic [4:0] a0, input logic [4:0] a1,
                                input logic [31:0] bp0, input logic [31:0] bp1,
                                input logic [31:0] nb0, input logic [31:0] nb1,
                                input logic [1:0] pnd);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra; v.en = en;
        v.a0 = a0; v.a1 = a1; v.bp0 = bp0; v.bp1 = bp1; v.nb0 = nb0; v.nb1 = nb1;
        v.pnd = pnd;
        return v;
    endfunction

    // ---------------- reference model ----------------
    logic [31:0] m_rf [DEPTH];
    bit          m_pend [DEPTH];
    int          m_left;
    logic [31:0] m_bp [2];
    logic [31:0] m_nb [2];
    bit          m_pd [2];

    task automatic model_reset();
        for (int k = 0; k < DEPTH; k++) begin
            m_rf[k]   = '0;
            m_pend[k] = 1'b0;
        end
        m_left = 0;
        for (int k = 0; k < 2; k++) begin
            m_bp[k] = '0; m_nb[k] = '0; m_pd[k] = 1'b0;
        end
    endtask

    // Apply one edge worth of the specified behaviour to the model.
    task automatic model_step();
        bit          np [DEPTH];
        logic [4:0]  a;
        logic [31:0] old;
        if (m_left > 0) begin
            for (int k = 0; k < 2; k++)
                if (rd_en[k]) begin
                    m_bp[k] = '0; m_nb[k] = '0; m_pd[k] = 1'b0;
                end
            m_rf[DEPTH - m_left]   = '0;
            m_pend[DEPTH - m_left] = 1'b0;
            m_left--;
        end else begin
            np = m_pend;
            if (wr_en)  np[wr_addr]  = 1'b0;
            if (rsv_en) np[rsv_addr] = 1'b1;
            np[0] = 1'b0;
            for (int k = 0; k < 2; k++)
                if (rd_en[k]) begin
                    a   = rd_addr[k*5 +: 5];
                    old = (a == 0) ? 32'd0 : m_rf[a];
                    m_nb[k] = old;
                    m_bp[k] = (wr_en && a == wr_addr && a != 0) ? wr_data : old;
                    m_pd[k] = np[a];
                end
            if (wr_en && wr_addr != 0) m_rf[wr_addr] = wr_data;
            m_pend = np;
            if (clr_req) m_left = DEPTH;
        end
    endtask

    // Pulse clr_req and count cycles with clr_busy high; optional mid-clear poke.
    task automatic run_clear(input string tag, input int poke_at, output int n);
        check({tag, " busy before"}, {31'd0, busy_bp}, 32'd0);
        tick();
        idle();
        n = 0;
        while (busy_bp && n < 100) begin
            n++;
            if (n == poke_at)
                drive(1'b1, 5'd4, 32'h4444_4444, 1'b1, 5'd4, 2'b11, 5'd4, 5'd4);
            else
                idle();
            tick();
            if (n == poke_at) begin
                check({tag, " mid bp data0"}, data_bp[31:0], 32'd0);
                check({tag, " mid nb data1"}, data_nb[63:32], 32'd0);
                check({tag, " mid pend"}, {30'd0, pend_bp}, 32'd0);
            end
        end
        idle();
        check({tag, " busy cycles"}, n, 32'd32);
        check({tag, " nb busy after"}, {31'd0, busy_nb}, 32'd0);
    endtask

    int n;

    initial begin
        tbl[0]  = mk(1, 7, 32'hDEADBEEF, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00);
        tbl[1]  = mk(0, 0, 0, 0, 0, 2'b01, 7, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 2'b00);
        tbl[2]  = mk(1, 0, 32'h1234, 0, 0, 2'b00, 0, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 2'b00);
        tbl[3]  = mk(0, 0, 0, 0, 0, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00);
        tbl[4]  = mk(1, 3, 32'h11, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00);
        tbl[5]  = mk(1, 3, 32'h22, 0, 0, 2'b11, 3, 3, 32'h22, 32'h22, 32'h11, 32'h11, 2'b00);
        tbl[6]  = mk(0, 0, 0, 0, 0, 2'b11, 3, 3, 32'h22, 32'h22, 32'h22, 32'h22, 2'b00);
        tbl[7]  = mk(0, 0, 0, 1, 9, 2'b00, 0, 0, 32'h22, 32'h22, 32'h22, 32'h22, 2'b00);
        tbl[8]  = mk(0, 0, 0, 0, 0, 2'b11, 9, 9, 0, 0, 0, 0, 2'b11);
        tbl[9]  = mk(1, 9, 32'h99, 0, 0, 2'b11, 9, 9, 32'h99, 32'h99, 0, 0, 2'b00);
        tbl[10] = mk(1, 9, 32'hAA, 1, 9, 2'b11, 9, 3, 32'hAA, 32'h22, 32'h99, 32'h22, 2'b01);
        tbl[11] = mk(0, 0, 0, 0, 0, 2'b11, 9, 31, 32'hAA, 0, 32'hAA, 0, 2'b01);
        tbl[12] = mk(0, 0, 0, 1, 31, 2'b11, 31, 31, 0, 0, 0, 0, 2'b11);
        tbl[13] = mk(1, 31, 32'h5, 1, 0, 2'b11, 0, 31, 0, 32'h5, 0, 0, 2'b00);

        // Reset state
        reset = 1'b1;
        idle();
        #3;
        check_all_zero("reset");
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_all_zero("post reset");

        // Directed table
        for (int r = 0; r < 14; r++) begin
            drive(tbl[r].we, tbl[r].wa, tbl[r].wd, tbl[r].re, tbl[r].ra,
                  tbl[r].en, tbl[r].a0, tbl[r].a1);
            tick();
            check($sformatf("row%0d bp0", r), data_bp[31:0], tbl[r].bp0);
            check($sformatf("row%0d bp1", r), data_bp[63:32], tbl[r].bp1);
            check($sformatf("row%0d nb0", r), data_nb[31:0], tbl[r].nb0);
            check($sformatf("row%0d nb1", r), data_nb[63:32], tbl[r].nb1);
            check($sformatf("row%0d bp pend", r), {30'd0, pend_bp}, {30'd0, tbl[r].pnd});
            check($sformatf("row%0d nb pend", r), {30'd0, pend_nb}, {30'd0, tbl[r].pnd});
            check($sformatf("row%0d busy", r), {31'd0, busy_bp}, 32'd0);
        end
        idle();

        // Mid-cycle asynchronous reset, then reads of r5 / r31 on both ports
        #3;
        reset = 1'b1;
        #1;
        check_all_zero("async reset");
        @(negedge clock);
        reset = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 2'b11, 5'd5, 5'd31);
        tick();
        check_all_zero("read r5 r31");
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 2'b11, 5'd31, 5'd5);
        tick();
        check_all_zero("read r31 r5");

        // Bulk clear: fill and reserve r1..r31, then sweep
        for (int a = 1; a < DEPTH; a++) begin
            drive(1'b1, 5'(a), 32'h1000_0001 + 32'(a) * 32'd3, 1'b1, 5'(a), 2'b00, 5'd0, 5'd0);
            tick();
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 2'b11, 5'd17, 5'd4);
        tick();
        check("fill r17", data_bp[31:0], 32'h1000_0001 + 32'd51);
        check("fill r4 pend", {30'd0, pend_nb}, 32'd3);
        idle();
        clr_req = 1'b1;
        run_clear("clear1", 6, n);
        for (int a = 0; a < DEPTH; a++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 2'b11, 5'(a), 5'(DEPTH - 1 - a));
            tick();
            check_all_zero($sformatf("after clear r%0d", a));
        end
        idle();

        // Reset at clear cycle 10, then a fresh clear with a same-cycle write
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        check("clear2 busy at 10", {31'd0, busy_bp}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("reset mid clear bp", {31'd0, busy_bp}, 32'd0);
        check("reset mid clear nb", {31'd0, busy_nb}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        drive(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 2'b00, 5'd0, 5'd0);
        clr_req = 1'b1;
        run_clear("clear3", 0, n);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 2'b11, 5'd6, 5'd6);
        tick();
        check_all_zero("write then clear r6");
        idle();

        // Randomized traffic against the reference model
        reset = 1'b1;
        #3;
        reset = 1'b0;
        model_reset();
        for (int c = 0; c < 2000; c++) begin
            wr_en    = ($urandom % 2) == 0;
            wr_addr  = (($urandom % 4) == 0) ? 5'($urandom % 32) : 5'($urandom % 8);
            wr_data  = $urandom;
            rsv_en   = ($urandom % 3) == 0;
            rsv_addr = (($urandom % 4) == 0) ? 5'($urandom % 32) : 5'($urandom % 8);
            rd_en    = 2'($urandom % 4);
            rd_addr  = {5'($urandom % 8), 5'($urandom % 8)};
            clr_req  = ($urandom % 150) == 0;
            model_step();
            tick();
            for (int k = 0; k < 2; k++) begin
                check($sformatf("rand c%0d bp%0d", c, k), data_bp[k*32 +: 32], m_bp[k]);
                check($sformatf("rand c%0d nb%0d", c, k), data_nb[k*32 +: 32], m_nb[k]);
                check($sformatf("rand c%0d pend%0d", c, k), {31'd0, pend_bp[k]}, {31'd0, m_pd[k]});
            end
            check($sformatf("rand c%0d busy", c), {31'd0, busy_bp}, (m_left > 0) ? 32'd1 : 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
